pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the Mini-CPU fetch stage; replaces the fixed "PC + 4" combinational adder.
- Holds the PC register and selects the next PC from sequential increment, branch, jump, call/return and trap vector sources.
- Contains an internal return-address stack (RAS) for call/return.
- Provides stall and halt control and reports misaligned targets and RAS errors to the control unit.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- INC, 4, sequential increment in bytes; must be a power of two.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap or on an internal error.
- RAS_DEPTH, 4, number of return-address stack entries; must be ≥ 2 and a power of two.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  holds the PC and the RAS; all requests except trap are ignored.
- halt  input  1  enter HALT state.
- resume  input  1  leave HALT state.
- branch_taken  input  1  load branch_target.
- branch_target  input  ADDR_W  branch destination.
- jump  input  1  load jump_target.
- jump_target  input  ADDR_W  jump destination; also the call destination.
- call  input  1  push pc+INC onto the RAS, then load jump_target.
- ret  input  1  pop the RAS and load the popped value.
- trap  input  1  load TRAP_VEC.
- pc  output  ADDR_W  current PC (registered).
- pc_next_seq  output  ADDR_W  combinational pc+INC, modulo 2^ADDR_W.
- pc_valid  output  1  pc holds a fetchable address.
- misalign  output  1  one-cycle pulse: the selected target was misaligned.
- ras_err  output  1  one-cycle pulse: pop on an empty RAS.
- ras_empty  output  1  RAS count is 0.
- ras_full  output  1  RAS count is RAS_DEPTH.

Behaviour:
- Reset (asynchronous, rst=1):
  - pc = RESET_VEC, pc_valid = 0, misalign = 0, ras_err = 0.
  - RAS count = 0, so ras_empty = 1 and ras_full = 0.
  - FSM enters BOOT. Reset asserted mid-operation discards all pending state.
- FSM states:
  - BOOT: exactly one cycle after rst deasserts, pc_valid = 0. Moves to RUN unconditionally.
  - RUN: pc_valid = 1. halt=1 (with no trap) → HALT; pc is held.
  - HALT: pc_valid = 0, pc and RAS are held. resume=1 → RUN. trap=1 → load TRAP_VEC and go to RUN.
- Next-PC priority in RUN, evaluated each cycle:
  - trap, then ret, then call, then jump, then branch_taken, then sequential increment (pc+INC).
  - Only the highest-priority request acts; the others are dropped with no side effect (e.g. call+ret together → only the pop occurs).
- Stall:
  - stall=1 → pc, RAS and FSM are held.
  - trap still takes effect; it overrides stall and halt.
- Arithmetic:
  - All additions are modulo 2^ADDR_W.
  - Wrap from the maximum address to 0 is legal and silent.
- Alignment:
  - A target is misaligned when its low log2(INC) bits are nonzero.
  - Applies to branch, jump, call and ret targets.
  - Misaligned target → pc = TRAP_VEC and misalign pulses for one cycle.
  - For a misaligned call: the push is still performed, then pc = TRAP_VEC.
- RAS:
  - Circular buffer with a top pointer and a saturating count.
  - Push when full → overwrites the oldest entry; count stays RAS_DEPTH; no error.
  - Pop when empty → pc = TRAP_VEC and ras_err pulses; count stays 0.
  - Pop returns the most recent push (LIFO).
- Latency:
  - One cycle from request to pc update.
  - pc_next_seq follows pc combinationally.

Decomposition:
- Shared package pc_pkg:
  - FSM state typedef (BOOT, RUN, HALT).
  - next-PC source encoding (SRC_SEQ, SRC_BR, SRC_JMP, SRC_CALL, SRC_RET, SRC_TRAP).
  - Default vector constants.
- One sub-module: pc_ras (parametrised LIFO).
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full, underflow.
- The pc_sequencer top contains the FSM, the priority mux and the alignment check.

Test Plan:
- Reset release → pc=0 and pc_valid=0 for 1 cycle, then pc = 0, 4, 8, 12 on successive cycles with pc_valid=1.
- At pc=0x10, call with jump_target=0x200, then ret two cycles later → pc sequence 0x200, 0x204, 0x14; ras_empty returns to 1.
- 5 nested calls with RAS_DEPTH=4, then 5 rets → the first 4 rets return correct addresses, newest first; the 5th gives pc=0x100 and an ras_err pulse.
- branch_taken with branch_target=0x202 → pc=0x100 and a 1-cycle misalign pulse; branch and jump together → jump wins.
- stall=1 for 3 cycles with jump asserted → pc unchanged; trap during stall → pc=0x100 on the next cycle.
- halt at pc=0x40 → pc holds and pc_valid=0; resume → 0x44; ADDR_W=8 with pc=0xFC → next pc=0x00; rst pulsed mid-RUN → pc=RESET_VEC immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter sequencer.
//   pc_state_e : sequencer FSM states (BOOT, RUN, HALT)
//   pc_src_e   : next-PC source selected by the priority mux
//   DEF_*_VEC  : default reset and trap vectors (32-bit, cast to ADDR_W by users)
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JMP  = 3'd2,
    SRC_CALL = 3'd3,
    SRC_RET  = 3'd4,
    SRC_TRAP = 3'd5
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
// Return-address stack: circular buffer with a top pointer and a saturating
// entry count. Pushing when full overwrites the oldest entry silently.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   push_i         : write push_data_i as the new top
//   pop_i          : discard the current top (no effect when empty)
//   push_data_i    : return address to store
//   top_o          : most recently pushed entry (combinational read)
//   empty_o/full_o : count == 0 / count == DEPTH
//   underflow_o    : pop requested while empty
// push_i and pop_i are expected to be mutually exclusive; push wins if not.
// -----------------------------------------------------------------------------
module pc_ras #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic [DATA_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              underflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr;

  // DEPTH is a power of two, so the pointer wraps naturally.
  assign wr_ptr = top_q + PTR_W'(1);

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push_i) begin
      top_d = wr_ptr;
      if (cnt_q != CNT_W'(DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && (cnt_q != '0)) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count guards every read that matters.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr] <= push_data_i;
    end
  end

  // Read is combinational so a return resolves in the same cycle it is seen.
  assign top_o       = mem_q[top_q];
  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign underflow_o = pop_i && !push_i && empty_o;

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage program counter: holds the PC and picks the next one from
// trap > ret > call > jump > branch > sequential, with a return-address stack,
// stall/halt control and error pulses for misaligned targets and RAS underflow.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   stall_i               : hold pc/RAS/FSM (trap still acts)
//   halt_i / resume_i     : enter / leave HALT
//   branch_taken_i, branch_target_i : branch request and destination
//   jump_i, jump_target_i : jump request; jump_target_i is also the call target
//   call_i / ret_i        : push pc+INC and jump / pop and return
//   trap_i                : load TRAP_VEC (overrides stall and halt)
//   pc_o                  : registered PC
//   pc_next_seq_o         : pc_o + INC (combinational, wraps)
//   pc_valid_o            : high in RUN only
//   misalign_o, ras_err_o : one-cycle pulses aligned with the pc update
//   ras_empty_o, ras_full_o : RAS occupancy flags
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          INC       = 4,
  parameter logic [ADDR_W-1:0]    RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0]    TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic              trap_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_seq_o,
  output logic              pc_valid_o,
  output logic              misalign_o,
  output logic              ras_err_o,
  output logic              ras_empty_o,
  output logic              ras_full_o
);

  localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
  // Any set bit below the increment granule means the target is misaligned.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              ras_err_q, ras_err_d;

  pc_src_e           src;
  logic              advance;
  logic [ADDR_W-1:0] target;
  logic              ras_push, ras_pop, ras_underflow;
  logic [ADDR_W-1:0] ras_top;

  assign pc_next_seq_o = pc_q + INC_V;

  // FSM and request arbitration. Only the winning source is reported, so
  // lower-priority requests in the same cycle have no side effect.
  always_comb begin
    state_d = state_q;
    src     = SRC_SEQ;
    advance = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (trap_i) begin
          src     = SRC_TRAP;
          advance = 1'b1;
        end else if (!stall_i) begin
          if (halt_i) begin
            state_d = ST_HALT;
          end else begin
            advance = 1'b1;
            if (ret_i)               src = SRC_RET;
            else if (call_i)         src = SRC_CALL;
            else if (jump_i)         src = SRC_JMP;
            else if (branch_taken_i) src = SRC_BR;
            else                     src = SRC_SEQ;
          end
        end
      end
      ST_HALT: begin
        if (trap_i) begin
          src     = SRC_TRAP;
          advance = 1'b1;
          state_d = ST_RUN;
        end else if (!stall_i && resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // A misaligned call still pushes its return address before trapping.
  assign ras_push = advance && (src == SRC_CALL);
  assign ras_pop  = advance && (src == SRC_RET);

  // Target selection and error handling for the winning source.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    ras_err_d  = 1'b0;
    case (src)
      SRC_BR:            target = branch_target_i;
      SRC_JMP, SRC_CALL: target = jump_target_i;
      SRC_RET:           target = ras_top;
      SRC_TRAP:          target = TRAP_VEC;
      default:           target = pc_next_seq_o;
    endcase
    if (advance) begin
      if (src == SRC_TRAP) begin
        pc_d = TRAP_VEC;
      end else if (ras_underflow) begin
        pc_d      = TRAP_VEC;
        ras_err_d = 1'b1;
      end else if ((src != SRC_SEQ) && ((target & ALIGN_MASK) != '0)) begin
        pc_d       = TRAP_VEC;
        misalign_d = 1'b1;
      end else begin
        pc_d = target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      ras_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      ras_err_q  <= ras_err_d;
    end
  end

  pc_ras #(
    .DATA_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_next_seq_o),
    .top_o       (ras_top),
    .empty_o     (ras_empty_o),
    .full_o      (ras_full_o),
    .underflow_o (ras_underflow)
  );

  assign pc_o       = pc_q;
  assign pc_valid_o = (state_q == ST_RUN);
  assign misalign_o = misalign_q;
  assign ras_err_o  = ras_err_q;

endmodule
